// File: rtl/ahb_router_pkg.sv
// Shared constants, state enums and decode helpers for the AHB memory router.
// Bank codes are taken from the two address bits at BANK_LSB.
package ahb_router_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] BANK_INST = 2'd0;
  localparam logic [1:0] BANK_DATA = 2'd1;
  localparam logic [1:0] BANK_REG  = 2'd2;
  localparam logic [1:0] BANK_NONE = 2'd3;

  typedef enum logic [2:0] {
    PS_IDLE, PS_PEND, PS_ACCESS, PS_RESP, PS_ERR1, PS_ERR2
  } port_state_e;

  typedef enum logic {MODE_LOAD, MODE_RUN} mode_e;

  function automatic logic [3:0] size_to_wben(input logic [2:0] hsize, input logic [1:0] addr_lo);
    case (hsize)
      HSIZE_BYTE: size_to_wben = 4'b0001 << addr_lo;
      HSIZE_HALF: size_to_wben = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    size_to_wben = 4'b1111;
    endcase
  endfunction

  // wr_ok clears for read-only masters, port_ok clears for masters locked out by the mode
  function automatic logic is_legal(input logic [1:0] bank, input logic [2:0] hsize,
                                    input logic [1:0] addr_lo, input logic hwrite,
                                    input logic wr_ok, input logic port_ok);
    is_legal = port_ok && (bank != BANK_NONE) && (hsize <= HSIZE_WORD) &&
               !((hsize == HSIZE_HALF) && addr_lo[0]) &&
               !((hsize == HSIZE_WORD) && (addr_lo != 2'b00)) &&
               !(hwrite && !wr_ok);
  endfunction

endpackage

// File: rtl/ahb_router_port.sv
// One AHB-lite slave port: address latch, legality check, request/grant handshake
// and the two-cycle error response.
module ahb_router_port
  import ahb_router_pkg::*;
#(
  parameter int BANK_LSB = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic        wr_ok,
  input  logic        port_ok,
  input  logic        gnt,
  input  logic [31:0] rd_data,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  output logic        req,
  output logic [1:0]  req_bank,
  output logic        access,
  output logic        is_idle,
  output logic [1:0]  bank_q,
  output logic [31:0] addr_q,
  output logic        write_q,
  output logic [2:0]  size_q
);

  port_state_e state_q, state_d;
  logic [1:0]  bank_d;
  logic [31:0] addr_d;
  logic        write_d;
  logic [2:0]  size_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [1:0]  cur_bank;
  logic        xfer, legal, accept;

  assign cur_bank = haddr[BANK_LSB+1:BANK_LSB];
  assign xfer     = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  assign legal    = is_legal(cur_bank, hsize, haddr[1:0], hwrite, wr_ok, port_ok);
  assign accept   = hready && xfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= PS_IDLE;
      bank_q   <= BANK_INST;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= HSIZE_BYTE;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    hrdata_d = hrdata;
    case (state_q)
      PS_IDLE, PS_RESP, PS_ERR2: begin
        state_d = PS_IDLE;
        if (accept) begin
          bank_d  = cur_bank;
          addr_d  = haddr;
          write_d = hwrite;
          size_d  = hsize;
          if (!legal)   state_d = PS_ERR1;
          else if (gnt) state_d = PS_ACCESS;
          else          state_d = PS_PEND;
        end
      end
      PS_PEND:   if (gnt) state_d = PS_ACCESS;
      PS_ACCESS: state_d = PS_RESP;
      PS_ERR1:   state_d = PS_ERR2;
      default:   state_d = PS_IDLE;
    endcase
  end

  always_comb begin
    hready   = 1'b1;
    hresp    = 1'b0;
    hrdata   = hrdata_q;
    req      = 1'b0;
    req_bank = cur_bank;
    access   = 1'b0;
    is_idle  = 1'b0;
    case (state_q)
      PS_IDLE:   begin is_idle = 1'b1; req = xfer && legal; end
      PS_RESP:   begin hrdata = rd_data; req = xfer && legal; end
      PS_ERR2:   begin hresp = 1'b1; req = xfer && legal; end
      PS_PEND:   begin hready = 1'b0; req = 1'b1; req_bank = bank_q; end
      PS_ACCESS: begin hready = 1'b0; access = 1'b1; end
      PS_ERR1:   begin hready = 1'b0; hresp = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/ahb_mem_router.sv
// Routes the SPI loader and the two core ports onto the inst/data/reg targets
// and sequences the LOAD -> RUN boot mode.
module ahb_mem_router
  import ahb_router_pkg::*;
#(
  parameter int RAM_AW   = 14,
  parameter int REG_AW   = 4,
  parameter int BANK_LSB = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_done,
  output logic              core_en,
  input  logic [31:0]       spi_haddr,  imem_haddr,  dmem_haddr,
  input  logic              spi_hwrite, imem_hwrite, dmem_hwrite,
  input  logic [2:0]        spi_hsize,  imem_hsize,  dmem_hsize,
  input  logic [1:0]        spi_htrans, imem_htrans, dmem_htrans,
  input  logic [31:0]       spi_hwdata, imem_hwdata, dmem_hwdata,
  output logic [31:0]       spi_hrdata, imem_hrdata, dmem_hrdata,
  output logic              spi_hready, imem_hready, dmem_hready,
  output logic              spi_hresp,  imem_hresp,  dmem_hresp,
  output logic [RAM_AW-1:0] inst_addr,  data_addr,
  output logic [REG_AW-1:0] reg_addr,
  output logic [31:0]       inst_write, data_write, reg_write,
  output logic [3:0]        inst_wben,  data_wben,  reg_wben,
  output logic              inst_rwn,   data_rwn,   reg_rwn,
  input  logic [31:0]       inst_read,  data_read,  reg_read
);

  mode_e mode_q, mode_d;
  logic run;
  // per-port arrays: 0 = spi, 1 = imem, 2 = dmem
  logic [31:0] haddr_a [3], hwdata_a [3], hrdata_a [3], rdsel [3], aaddr [3];
  logic [2:0]  hsize_a [3], asize [3];
  logic [1:0]  htrans_a [3], rbank [3], abank [3];
  logic [2:0]  hwrite_a, hready_a, hresp_a, req, gnt, acc, idle, awr, wr_ok, port_ok;

  assign haddr_a  = '{spi_haddr,  imem_haddr,  dmem_haddr};
  assign hwdata_a = '{spi_hwdata, imem_hwdata, dmem_hwdata};
  assign hsize_a  = '{spi_hsize,  imem_hsize,  dmem_hsize};
  assign htrans_a = '{spi_htrans, imem_htrans, dmem_htrans};
  assign hwrite_a = {dmem_hwrite, imem_hwrite, spi_hwrite};
  assign wr_ok    = 3'b101;
  assign port_ok  = {1'b1, 1'b1, !run};

  assign spi_hrdata  = hrdata_a[0];
  assign imem_hrdata = hrdata_a[1];
  assign dmem_hrdata = hrdata_a[2];
  assign {dmem_hready, imem_hready, spi_hready} = hready_a;
  assign {dmem_hresp,  imem_hresp,  spi_hresp}  = hresp_a;

  for (genvar p = 0; p < 3; p++) begin : g_port
    ahb_router_port #(.BANK_LSB(BANK_LSB)) u_port (
      .clk(clk), .reset(reset), .haddr(haddr_a[p]), .hwrite(hwrite_a[p]),
      .hsize(hsize_a[p]), .htrans(htrans_a[p]), .wr_ok(wr_ok[p]), .port_ok(port_ok[p]),
      .gnt(gnt[p]), .rd_data(rdsel[p]), .hrdata(hrdata_a[p]), .hready(hready_a[p]),
      .hresp(hresp_a[p]), .req(req[p]), .req_bank(rbank[p]), .access(acc[p]),
      .is_idle(idle[p]), .bank_q(abank[p]), .addr_q(aaddr[p]), .write_q(awr[p]),
      .size_q(asize[p])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mode_q <= MODE_LOAD;
    else        mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if ((mode_q == MODE_LOAD) && spi_done && idle[0]) mode_d = MODE_RUN;
  end

  always_comb begin
    run     = (mode_q == MODE_RUN);
    core_en = run;
  end

  // a grant this cycle means that target is driven in ACCESS next cycle
  always_comb begin
    gnt[0] = !run && req[0];
    gnt[2] = run && req[2];
    gnt[1] = run && req[1] && !(req[2] && (rbank[2] == rbank[1]));
  end

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      case (abank[p])
        BANK_INST: rdsel[p] = inst_read;
        BANK_DATA: rdsel[p] = data_read;
        BANK_REG:  rdsel[p] = reg_read;
        default:   rdsel[p] = '0;
      endcase
    end
  end

  logic [29:0] tw_addr [3];
  logic [31:0] tw_data [3];
  logic [3:0]  tw_wben [3];
  logic [2:0]  tw_act, tw_wr;
  logic [RAM_AW-1:0] inst_addr_q, inst_addr_d, data_addr_q, data_addr_d;
  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic [31:0] inst_write_q, inst_write_d, data_write_q, data_write_d, reg_write_q, reg_write_d;
  logic unused_addr;

  always_comb begin
    for (int t = 0; t < 3; t++) begin
      tw_act[t]  = 1'b0;
      tw_wr[t]   = 1'b0;
      tw_addr[t] = '0;
      tw_data[t] = '0;
      tw_wben[t] = '0;
      for (int p = 0; p < 3; p++) begin
        if (acc[p] && (abank[p] == 2'(t))) begin
          tw_act[t]  = 1'b1;
          tw_wr[t]   = awr[p];
          tw_addr[t] = aaddr[p][31:2];
          tw_data[t] = hwdata_a[p];
          tw_wben[t] = size_to_wben(asize[p], aaddr[p][1:0]);
        end
      end
    end
    inst_addr_d  = tw_act[0] ? tw_addr[0][RAM_AW-1:0] : inst_addr_q;
    data_addr_d  = tw_act[1] ? tw_addr[1][RAM_AW-1:0] : data_addr_q;
    reg_addr_d   = tw_act[2] ? tw_addr[2][REG_AW-1:0] : reg_addr_q;
    inst_write_d = tw_act[0] ? tw_data[0] : inst_write_q;
    data_write_d = tw_act[1] ? tw_data[1] : data_write_q;
    reg_write_d  = tw_act[2] ? tw_data[2] : reg_write_q;
  end

  assign unused_addr = ^{tw_addr[0], tw_addr[1], tw_addr[2]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_addr_q  <= '0;
      data_addr_q  <= '0;
      reg_addr_q   <= '0;
      inst_write_q <= '0;
      data_write_q <= '0;
      reg_write_q  <= '0;
    end else begin
      inst_addr_q  <= inst_addr_d;
      data_addr_q  <= data_addr_d;
      reg_addr_q   <= reg_addr_d;
      inst_write_q <= inst_write_d;
      data_write_q <= data_write_d;
      reg_write_q  <= reg_write_d;
    end
  end

  assign inst_addr  = inst_addr_d;
  assign data_addr  = data_addr_d;
  assign reg_addr   = reg_addr_d;
  assign inst_write = inst_write_d;
  assign data_write = data_write_d;
  assign reg_write  = reg_write_d;
  assign inst_wben  = tw_wben[0];
  assign data_wben  = tw_wben[1];
  assign reg_wben   = tw_wben[2];
  assign inst_rwn   = !(tw_act[0] && tw_wr[0]);
  assign data_rwn   = !(tw_act[1] && tw_wr[1]);
  assign reg_rwn    = !(tw_act[2] && tw_wr[2]);

endmodule

// File: doc/ahb_mem_router.md
# ahb_mem_router

Parametrised AHB-lite memory router between the three bus masters (SPI loader, RISC-V instruction port, RISC-V data port) and the three on-chip targets (instruction RAM, data RAM, register file). It replaces the fixed SPI-only write path with full address decode, read and write support, byte lanes, error responses and arbitration. It owns the LOAD→RUN boot-mode sequence: SPI has exclusive access during LOAD, and the core ports are arbitrated during RUN.

## Interface
- `RAM_AW`, default 14: word-address width of each RAM.
- `REG_AW`, default 4: word-address width of the register file.
- `BANK_LSB`, default 16: `haddr[BANK_LSB+1:BANK_LSB]` selects the bank: 0 = inst, 1 = data, 2 = reg, 3 = unmapped.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `spi_done`  in  1  loader finished; level-sensitive
- `core_en`  out  1  high in RUN; gates the core
- `{spi,imem,dmem}_haddr`  in  32  AHB address
- `{spi,imem,dmem}_hwrite`  in  1  write
- `{spi,imem,dmem}_hsize`  in  3  transfer size
- `{spi,imem,dmem}_htrans`  in  2  transfer type
- `{spi,imem,dmem}_hwdata`  in  32  write data (data phase)
- `{spi,imem,dmem}_hrdata`  out  32  read data
- `{spi,imem,dmem}_hready`  out  1  transfer done / address accepted
- `{spi,imem,dmem}_hresp`  out  1  error response
- `inst_addr`, `data_addr`  out  RAM_AW  RAM word address
- `reg_addr`  out  REG_AW  register word address
- `inst_write`, `data_write`, `reg_write`  out  32  write data
- `inst_wben`, `data_wben`, `reg_wben`  out  4  byte enables (bit n = byte n)
- `inst_rwn`, `data_rwn`, `reg_rwn`  out  1  1 = read/idle, 0 = write
- `inst_read`, `data_read`, `reg_read`  in  32  synchronous read data, valid the cycle after address

## Operation
- Mode FSM: LOAD (reset state) → RUN when `spi_done`=1 and the SPI port is IDLE; RUN is left only by reset.
- Per-port FSM: IDLE, PEND, ACCESS, RESP, ERR1, ERR2.
  - A port accepts an address phase when its `hready`=1 and `htrans[1]`=1; it latches addr, write, size and bank.
  - Illegal transfers go IDLE→ERR1. Illegal means: unmapped bank; hsize>2; misaligned (half at odd address, word with `haddr[1:0]`≠0); imem write; SPI transfer in RUN.
  - Legal transfers go to ACCESS if granted that cycle, else to PEND.
  - ACCESS→RESP→IDLE. ERR1→ERR2→IDLE.
- Grant rules, per target, one per cycle:
  - LOAD: SPI only. Core requests are accepted and held in PEND until RUN.
  - RUN: dmem beats imem when both target the same bank. Different banks are served concurrently.
- ACCESS drives the target: addr = `haddr[AW+1:2]`; write data from `hwdata`; rwn = !write.
- Byte enables:
  - byte: `1<<haddr[1:0]`
  - half: `3<<{haddr[1],0}`
  - word: `F`
  - reads also drive wben per size.
- RESP: `hrdata` = selected target's `*_read`.
- Idle target: rwn=1, wben=0, addr and write data hold their last value.

## Timing
- Reset values:
  - all `hready`=1, `hresp`=0, `hrdata`=0
  - all `rwn`=1, `wben`=0, addr=0, write=0
  - `core_en`=0, mode LOAD.
- Reset mid-transfer: everything is abandoned. No write is issued after `reset` falls.
- Uncontended transfer: address accepted at edge E0.
  - Cycle after E0 (ACCESS): `hready`=0, target command driven; the RAM captures it at E1.
  - Cycle after E1 (RESP): `hready`=1, `hrdata` valid.
  - Throughput: one transfer per 2 cycles per port.
- Each PEND cycle adds one `hready`=0 cycle.
- Error responses:
  - ERR1: `hready`=0, `hresp`=1.
  - ERR2: `hready`=1, `hresp`=1.
  - No target access occurs.
- `core_en` rises the cycle after the LOAD→RUN edge.
- Core ports see `hready`=1 in LOAD until they present a transfer.
- `hrdata` holds its last value outside RESP.

## Structure
- Package `ahb_router_pkg` holds:
  - HTRANS and HSIZE constants
  - bank codes
  - port-state and mode enums
  - function `size_to_wben(hsize, addr[1:0])`
  - function `is_legal(...)`
- Sub-module `ahb_router_port`: one per master. It holds the port FSM, address latch and error logic, outputs request/bank, and takes grant in.
- Top level holds the mode FSM, grant logic and target muxes.

## Test plan
- Reset, then SPI word write to 0x0000_0010 data 0xDEADBEEF → `inst_addr`=4, `inst_wben`=F, `inst_rwn`=0 in ACCESS; SPI `hready` low exactly 1 cycle.
- SPI byte write to 0x0001_0003 data 0x55000000 → `data_wben`=8, `data_addr`=0. Then SPI halfword read of 0x0001_0002 → RESP returns `data_read`.
- In LOAD, imem read of 0x0 → `hready` stays 0 until `spi_done`=1. `core_en` rises, then the read completes 3 cycles after the mode change.
- RUN: imem and dmem both read bank 0 at the same edge → dmem served first; imem gets one extra wait cycle, then its RESP.
- Error cases: dmem read of 0x0003_0000, word access at 0x0001_0002, imem write, SPI access in RUN → each gives the two-cycle error; no `rwn`/`wben` activity.
- Reset asserted during ACCESS of a write → `inst_rwn`=1 and `wben`=0 immediately; mode LOAD, `core_en`=0.
